// File: rtl/i2c_pkg.sv
// Shared I2C/SCCB definitions: FSM state encoding, SCCB address constants and
// small helpers used by both the target and the initiator.
package i2c_pkg;

  localparam logic [6:0] SCCB_ADDR    = 7'h21;
  localparam logic [7:0] SCCB_WR_BYTE = {SCCB_ADDR, 1'b0};
  localparam logic [7:0] SCCB_RD_BYTE = {SCCB_ADDR, 1'b1};

  localparam int                   BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  // The 7-bit address occupies the upper bits of the first byte; bit 0 is R/W.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
    return addr_byte[7:1] == dev_addr;
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins and user-side byte handshake of the I2C target, grouped as one bundle.
interface i2c_target_if;

  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_ack_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, wr_ack_en, rd_data,
    output sda_oe, wr_valid, wr_data, rd_req, start_det, stop_det, busy
  );

  modport master (
    output scl_i, sda_i, wr_ack_en, rd_data,
    input  sda_oe, wr_valid, wr_data, rd_req, start_det, stop_det, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_cond,
  output logic stop_cond
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;

  // Reset to 1 so an idle bus produces no edges when reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe[0] <= scl_i;
      sda_pipe[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_pipe[i] <= scl_pipe[i-1];
        sda_pipe[i] <= sda_pipe[i-1];
      end
      scl_prev <= scl_pipe[SYNC_STAGES-1];
      sda_prev <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_pipe[SYNC_STAGES-1];
  assign sda        = sda_pipe[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_cond = scl_s & scl_prev & sda_prev & ~sda;
  assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C/SCCB target: receives write bytes and serves read bytes through a
// one-pulse handshake, driving SDA open-drain via sda_oe.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = SCCB_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  i2c_target_if.slave bus
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  i2c_state_t           state, state_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [BIT_CNT_W-1:0] cnt_inc;
  logic                 bit_done;
  logic [7:0]           shift_reg, shift_n;
  logic                 rw_flag, rw_n;
  logic                 ack_flag, ack_n;
  logic                 sda_oe_r, sda_oe_n;
  logic                 busy_r, busy_n;
  logic [7:0]           wr_data_r, wr_data_n;
  logic                 wr_valid_r, wr_valid_n;
  logic                 rd_req_r, rd_req_n;
  logic                 start_det_r, stop_det_r;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_cond(start_cond),
    .stop_cond (stop_cond)
  );

  assign bit_done = (bit_cnt == BYTE_BITS);
  assign cnt_inc  = bit_done ? bit_cnt : bit_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rw_flag     <= 1'b0;
      ack_flag    <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      wr_data_r   <= '0;
      wr_valid_r  <= 1'b0;
      rd_req_r    <= 1'b0;
      start_det_r <= 1'b0;
      stop_det_r  <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift_reg   <= shift_n;
      rw_flag     <= rw_n;
      ack_flag    <= ack_n;
      sda_oe_r    <= sda_oe_n;
      busy_r      <= busy_n;
      wr_data_r   <= wr_data_n;
      wr_valid_r  <= wr_valid_n;
      rd_req_r    <= rd_req_n;
      start_det_r <= start_cond;
      stop_det_r  <= stop_cond;
    end
  end

  // START/STOP override bit handling; otherwise bits are taken on SCL rise
  // and SDA drive only moves on SCL fall.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    rw_n       = rw_flag;
    ack_n      = ack_flag;
    sda_oe_n   = sda_oe_r;
    busy_n     = busy_r;
    wr_data_n  = wr_data_r;
    wr_valid_n = 1'b0;
    rd_req_n   = 1'b0;

    if (start_cond) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_cond) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sda_oe_n = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift_reg[6:0], sda};
            bit_cnt_n = cnt_inc;
          end else if (scl_fall && bit_done) begin
            bit_cnt_n = '0;
            if (addr_match(shift_reg, DEV_ADDR)) begin
              state_n  = ST_ADDR_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shift_reg[0];
            end else begin
              state_n  = ST_IGNORE;
              sda_oe_n = 1'b0;
            end
          end
        end

        // A read request goes out early so rd_data is ready at the ACK fall.
        ST_ADDR_ACK: begin
          if (scl_rise) begin
            rd_req_n = rw_flag;
          end else if (scl_fall) begin
            bit_cnt_n = '0;
            if (rw_flag) begin
              state_n  = ST_RD_BYTE;
              shift_n  = bus.rd_data;
              sda_oe_n = ~bus.rd_data[7];
            end else begin
              state_n  = ST_WR_BYTE;
              sda_oe_n = 1'b0;
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_n   = {shift_reg[6:0], sda};
            bit_cnt_n = cnt_inc;
            if (bit_cnt == LAST_BIT) begin
              wr_data_n  = {shift_reg[6:0], sda};
              wr_valid_n = 1'b1;
            end
          end else if (scl_fall && bit_done) begin
            state_n  = ST_WR_ACK;
            sda_oe_n = bus.wr_ack_en;
            ack_n    = bus.wr_ack_en;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (ack_flag) begin
              state_n = ST_WR_BYTE;
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = cnt_inc;
          end else if (scl_fall) begin
            if (bit_done) begin
              state_n  = ST_RD_ACK;
              sda_oe_n = 1'b0;
              ack_n    = 1'b0;
            end else begin
              shift_n  = {shift_reg[6:0], 1'b0};
              sda_oe_n = ~shift_reg[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              rd_req_n = 1'b1;
              ack_n    = 1'b1;
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && ack_flag) begin
            state_n   = ST_RD_BYTE;
            bit_cnt_n = '0;
            shift_n   = bus.rd_data;
            sda_oe_n  = ~bus.rd_data[7];
          end
        end

        ST_IGNORE: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_r;
  assign bus.busy      = busy_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.wr_valid  = wr_valid_r;
  assign bus.rd_req    = rd_req_r;
  assign bus.start_det = start_det_r;
  assign bus.stop_det  = stop_det_r;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master plus a transaction-level model
// of what the target must do on each bit slot and which pulses it must emit.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;

  typedef enum {M_IDLE, M_ADDR, M_WRITE, M_READ, M_IGNORE} model_mode_t;

  logic clk;
  logic rst;
  logic scl_m;
  logic sda_m;
  logic wr_ack_en_tb;
  logic [7:0] rd_data_tb;

  i2c_target_if bus ();

  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & ~bus.sda_oe;
  assign bus.wr_ack_en = wr_ack_en_tb;
  assign bus.rd_data   = rd_data_tb;

  i2c_target #(
    .DEV_ADDR   (7'h21),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  model_mode_t mode;
  logic [7:0]  m_cur;
  logic [7:0]  model_tx[$];
  logic [7:0]  exp_wr[$];
  int          exp_start, exp_stop, exp_rd_req;

  // observed state
  logic [7:0]  tx_q[$];
  logic [7:0]  obs_wr[$];
  int          cnt_start, cnt_stop, cnt_rd_req, oe_hi_cycles;
  logic        prev_wr_valid, prev_rd_req, prev_start, prev_stop;

  // slot check request from the master
  logic check_slot;
  logic chk_busy;
  logic exp_oe;
  logic exp_busy;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL clock with the master driving bit_out; the slot check fires mid-high.
  task automatic applyStimulus(input logic bit_out, input logic exp_oe_v,
                               input logic do_busy, output logic line);
    sda_m = bit_out;
    wait_cycles(Q);
    scl_m = 1'b1;
    wait_cycles(Q);
    exp_oe     = exp_oe_v;
    exp_busy   = (mode == M_WRITE) || (mode == M_READ);
    chk_busy   = do_busy;
    check_slot = 1'b1;
    line       = sda_m & ~bus.sda_oe;
    wait_cycles(1);
    check_slot = 1'b0;
    wait_cycles(Q - 1);
    scl_m = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      wait_cycles(Q);
      scl_m = 1'b1;
      wait_cycles(Q);
    end
    sda_m = 1'b0;
    wait_cycles(Q);
    scl_m = 1'b0;
    wait_cycles(Q);
    mode = M_ADDR;
    exp_start++;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_cycles(Q);
    scl_m = 1'b1;
    wait_cycles(Q);
    sda_m = 1'b1;
    wait_cycles(Q);
    mode = M_IDLE;
    exp_stop++;
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic line;
    logic ack;
    if (mode == M_WRITE) exp_wr.push_back(b);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b0, 1'b1, line);
    ack = 1'b0;
    case (mode)
      M_ADDR: begin
        if (b[7:1] == 7'h21) begin
          ack = 1'b1;
          if (b[0]) begin
            mode = M_READ;
            exp_rd_req++;
            m_cur = (model_tx.size() != 0) ? model_tx.pop_front() : 8'hFF;
          end else begin
            mode = M_WRITE;
          end
        end else begin
          mode = M_IGNORE;
        end
      end
      M_WRITE: begin
        ack = wr_ack_en_tb;
        if (!wr_ack_en_tb) mode = M_IGNORE;
      end
      default: ack = 1'b0;
    endcase
    applyStimulus(1'b1, ack, 1'b0, line);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] got);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, (mode == M_READ) ? ~m_cur[i] : 1'b0, 1'b1, line);
      got[i] = line;
    end
    if (mode == M_READ) begin
      if (master_ack) begin
        exp_rd_req++;
        m_cur = (model_tx.size() != 0) ? model_tx.pop_front() : 8'hFF;
      end else begin
        mode = M_IGNORE;
      end
    end
    applyStimulus(~master_ack, 1'b0, 1'b0, line);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_q.push_back(b);
    model_tx.push_back(b);
  endtask

  task automatic clear_counts();
    cnt_start = 0; cnt_stop = 0; cnt_rd_req = 0; oe_hi_cycles = 0;
    exp_start = 0; exp_stop = 0; exp_rd_req = 0;
    obs_wr.delete(); exp_wr.delete(); tx_q.delete(); model_tx.delete();
  endtask

  task automatic end_scenario(input string tag);
    checkOutput({tag, "_start_count"}, 32'(cnt_start), 32'(exp_start));
    checkOutput({tag, "_stop_count"}, 32'(cnt_stop), 32'(exp_stop));
    checkOutput({tag, "_rd_req_count"}, 32'(cnt_rd_req), 32'(exp_rd_req));
    checkOutput({tag, "_wr_missing"}, 32'(exp_wr.size()), 32'd0);
  endtask

  // Compare process: slot expectations, write scoreboard, pulse widths and counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (check_slot) begin
        checkOutput("slot_sda_oe", 32'(bus.sda_oe), 32'(exp_oe));
        if (chk_busy) checkOutput("slot_busy", 32'(bus.busy), 32'(exp_busy));
      end
      if (bus.wr_valid) begin
        obs_wr.push_back(bus.wr_data);
        checkOutput("wr_valid_width", 32'(prev_wr_valid), 32'd0);
        if (exp_wr.size() == 0) checkOutput("wr_valid_unexpected", 32'(bus.wr_valid), 32'd0);
        else checkOutput("wr_data", 32'(bus.wr_data), 32'(exp_wr.pop_front()));
      end
      if (bus.rd_req)    checkOutput("rd_req_width", 32'(prev_rd_req), 32'd0);
      if (bus.start_det) checkOutput("start_det_width", 32'(prev_start), 32'd0);
      if (bus.stop_det)  checkOutput("stop_det_width", 32'(prev_stop), 32'd0);
      cnt_start    += int'(bus.start_det);
      cnt_stop     += int'(bus.stop_det);
      cnt_rd_req   += int'(bus.rd_req);
      oe_hi_cycles += int'(bus.sda_oe);
    end
    prev_wr_valid = bus.wr_valid;
    prev_rd_req   = bus.rd_req;
    prev_start    = bus.start_det;
    prev_stop     = bus.stop_det;
  end

  // User side: hand over the next read byte on each request.
  always @(negedge clk) begin
    if (!rst && bus.rd_req) begin
      if (tx_q.size() != 0) rd_data_tb = tx_q.pop_front();
      else rd_data_tb = 8'hFF;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] got0, got1;
    logic       line;
    int         n;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; wr_ack_en_tb = 1'b1; rd_data_tb = 8'h00;
    check_slot = 1'b0; chk_busy = 1'b0; exp_oe = 1'b0; exp_busy = 1'b0; mode = M_IDLE;
    prev_wr_valid = 1'b0; prev_rd_req = 1'b0; prev_start = 1'b0; prev_stop = 1'b0;
    clear_counts();
    wait_cycles(4);
    checkOutput("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst_pulses", 32'({bus.wr_valid, bus.rd_req, bus.start_det, bus.stop_det}), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    wait_cycles(4);

    // Write 0x12, 0x80 to the SCCB address
    clear_counts();
    bus_start(); write_byte(8'h42); write_byte(8'h12); write_byte(8'h80); bus_stop();
    end_scenario("wr2");
    checkOutput("wr2_count", 32'(obs_wr.size()), 32'd2);
    checkOutput("wr2_byte0", 32'(obs_wr[0]), 32'h12);
    checkOutput("wr2_byte1", 32'(obs_wr[1]), 32'h80);
    checkOutput("wr2_stop_lit", 32'(cnt_stop), 32'd1);

    // Single read of 0xA5 ending in master NACK
    clear_counts();
    load_tx(8'hA5);
    bus_start(); write_byte(8'h43); read_byte(1'b0, got0);
    checkOutput("rd1_byte", 32'(got0), 32'hA5);
    checkOutput("rd1_state_ignore", 32'(dut.state), 32'(ST_IGNORE));
    checkOutput("rd1_busy_after_nack", 32'(bus.busy), 32'd0);
    checkOutput("rd1_rd_req_lit", 32'(cnt_rd_req), 32'd1);
    bus_stop();
    end_scenario("rd1");

    // Address mismatch followed by two bytes
    clear_counts();
    bus_start(); write_byte(8'h60); write_byte(8'h5A); write_byte(8'hC3); bus_stop();
    end_scenario("miss");
    checkOutput("miss_oe_cycles", 32'(oe_hi_cycles), 32'd0);
    checkOutput("miss_wr_count", 32'(obs_wr.size()), 32'd0);

    // Write, repeated START, two reads
    clear_counts();
    load_tx(8'h3C); load_tx(8'hC3);
    bus_start(); write_byte(8'h42); write_byte(8'h0A);
    bus_start(); write_byte(8'h43); read_byte(1'b1, got0); read_byte(1'b0, got1); bus_stop();
    end_scenario("rs");
    checkOutput("rs_start_lit", 32'(cnt_start), 32'd2);
    checkOutput("rs_rd_byte0", 32'(got0), 32'h3C);
    checkOutput("rs_rd_byte1", 32'(got1), 32'hC3);
    checkOutput("rs_wr_byte", 32'(obs_wr[0]), 32'h0A);

    // Data NACK: byte still delivered, following byte ignored
    clear_counts();
    wr_ack_en_tb = 1'b0;
    bus_start(); write_byte(8'h42); write_byte(8'h55);
    checkOutput("nack_busy", 32'(bus.busy), 32'd0);
    checkOutput("nack_state", 32'(dut.state), 32'(ST_IGNORE));
    write_byte(8'h66); bus_stop();
    end_scenario("nack");
    checkOutput("nack_wr_count", 32'(obs_wr.size()), 32'd1);
    checkOutput("nack_wr_byte", 32'(obs_wr[0]), 32'h55);
    wr_ack_en_tb = 1'b1;

    // STOP after four bits of a data byte
    clear_counts();
    bus_start(); write_byte(8'h42);
    applyStimulus(1'b1, 1'b0, 1'b1, line);
    applyStimulus(1'b0, 1'b0, 1'b1, line);
    applyStimulus(1'b1, 1'b0, 1'b1, line);
    applyStimulus(1'b1, 1'b0, 1'b1, line);
    bus_stop();
    wait_cycles(4);
    end_scenario("short");
    checkOutput("short_wr_count", 32'(obs_wr.size()), 32'd0);
    checkOutput("short_state", 32'(dut.state), 32'(ST_IDLE));

    // Reset while the target drives the address ACK
    clear_counts();
    bus_start();
    for (int i = 7; i >= 0; i--) applyStimulus(got0[i] & 1'b0 | SCCB_WR_BYTE[i], 1'b0, 1'b1, line);
    sda_m = 1'b1;
    n = 0;
    while (!bus.sda_oe && n < 32) begin
      wait_cycles(1);
      n++;
    end
    checkOutput("ack_drive_before_rst", 32'(bus.sda_oe), 32'd1);
    scl_m = 1'b1;
    wait_cycles(2);
    checkOutput("mid_ack_state", 32'(dut.state), 32'(ST_ADDR_ACK));
    rst = 1'b1;
    wait_cycles(1);
    checkOutput("rst_ack_sda_oe", 32'(bus.sda_oe), 32'd0);
    checkOutput("rst_ack_state", 32'(dut.state), 32'(ST_IDLE));
    checkOutput("rst_ack_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_ack_wr_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b0;
    mode = M_IDLE;
    wait_cycles(8);
    checkOutput("post_rst_state", 32'(dut.state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
